// File: rtl/playfield_compositor_pkg.sv
// Shared video definitions for the playfield compositor and the blocks
// that will sit around it (score boxes, overlays).
//   - Default coordinate and colour widths.
//   - Named 3-bit colour constants.
//   - Default playfield border geometry.
//   - A small helper that flags the first active pixel of a frame.
package playfield_compositor_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_RGB_W   = 3;

  localparam logic [DEF_RGB_W-1:0] BLACK = 3'b000;
  localparam logic [DEF_RGB_W-1:0] BLUE  = 3'b001;
  localparam logic [DEF_RGB_W-1:0] WHITE = 3'b111;

  localparam int DEF_BX0   = 150;
  localparam int DEF_BY0   = 110;
  localparam int DEF_BX1   = 489;
  localparam int DEF_BY1   = 370;
  localparam int DEF_THICK = 10;

  localparam int DEF_FLASH_FRAMES = 30;

  // The frame starts at the top-left pixel, but only when it is actually
  // displayed; a blanked (0,0) must not retrigger the frame logic.
  function automatic logic is_frame_start(input logic x_zero,
                                          input logic y_zero,
                                          input logic active);
    return x_zero && y_zero && active;
  endfunction

endpackage

// File: rtl/playfield_compositor_if.sv
// Pixel bus between the timing/game-logic side and the compositor.
//   Inputs to the compositor : pix_x, pix_y, video_on, graph_on, graph_rgb,
//                              border_rgb_in, bg_rgb_in, flash_en
//   Outputs from compositor  : rgb, rgb_valid, frame_start
// The master modport is the pixel source (timing generator / bench); the
// slave modport is the compositor itself.
interface playfield_compositor_if #(
  parameter int COORD_W = 10,
  parameter int RGB_W   = 3
);

  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               video_on;
  logic               graph_on;
  logic [RGB_W-1:0]   graph_rgb;
  logic [RGB_W-1:0]   border_rgb_in;
  logic [RGB_W-1:0]   bg_rgb_in;
  logic               flash_en;

  logic [RGB_W-1:0]   rgb;
  logic               rgb_valid;
  logic               frame_start;

  modport master (
    output pix_x, pix_y, video_on, graph_on, graph_rgb,
           border_rgb_in, bg_rgb_in, flash_en,
    input  rgb, rgb_valid, frame_start
  );

  modport slave (
    input  pix_x, pix_y, video_on, graph_on, graph_rgb,
           border_rgb_in, bg_rgb_in, flash_en,
    output rgb, rgb_valid, frame_start
  );

endinterface

// File: rtl/playfield_compositor_rect_frame_hit.sv
// Combinational hollow-rectangle test: hit_o is high when (x_i,y_i) lies
// inside the outer rectangle [X0..X1]x[Y0..Y1] but not inside the inner
// rectangle shrunk by THICK on every side. All bounds are inclusive and
// compared unsigned at COORD_W bits.
//   x_i, y_i : pixel coordinate
//   hit_o    : coordinate is on the frame band
module rect_frame_hit #(
  parameter int COORD_W = 10,
  parameter int X0      = 150,
  parameter int Y0      = 110,
  parameter int X1      = 489,
  parameter int Y1      = 370,
  parameter int THICK   = 10
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               hit_o
);

  localparam logic [COORD_W-1:0] OX0 = COORD_W'(X0);
  localparam logic [COORD_W-1:0] OY0 = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] OX1 = COORD_W'(X1);
  localparam logic [COORD_W-1:0] OY1 = COORD_W'(Y1);
  localparam logic [COORD_W-1:0] IX0 = COORD_W'(X0 + THICK);
  localparam logic [COORD_W-1:0] IY0 = COORD_W'(Y0 + THICK);
  localparam logic [COORD_W-1:0] IX1 = COORD_W'(X1 - THICK);
  localparam logic [COORD_W-1:0] IY1 = COORD_W'(Y1 - THICK);

  logic in_outer;
  logic in_inner;

  always_comb begin
    in_outer = (x_i >= OX0) && (x_i <= OX1) && (y_i >= OY0) && (y_i <= OY1);
    in_inner = (x_i >= IX0) && (x_i <= IX1) && (y_i >= IY0) && (y_i <= IY1);
    hit_o    = in_outer && !in_inner;
  end

endmodule

// File: rtl/playfield_compositor.sv
// Playfield compositor: merges the game layer, a rectangular playfield
// border and a background colour into one registered RGB stream with a
// fixed two-cycle latency.
//   clk, reset : pixel clock, synchronous active-high reset
//   bus.slave  : pixel coordinates, layer inputs and requested colours in;
//                rgb, rgb_valid and frame_start out
// Colour and flash requests are sampled only at the first active pixel of
// each frame so the picture never tears mid-frame.
module playfield_compositor
  import playfield_compositor_pkg::*;
#(
  parameter int COORD_W      = DEF_COORD_W,
  parameter int RGB_W        = DEF_RGB_W,
  parameter int BX0          = DEF_BX0,
  parameter int BY0          = DEF_BY0,
  parameter int BX1          = DEF_BX1,
  parameter int BY1          = DEF_BY1,
  parameter int THICK        = DEF_THICK,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic                   clk,
  input  logic                   reset,
  playfield_compositor_if.slave  bus
);

  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  // Stage-1 combinational terms
  logic in_border;
  logic sof;

  // Stage-1 pipeline registers
  logic               graph_on_q;
  logic [RGB_W-1:0]   graph_rgb_q;
  logic               video_on_q;
  logic               in_border_q;
  logic               sof_q;

  // Frame-latched configuration and flash state
  logic [RGB_W-1:0]   border_q,      border_d;
  logic [RGB_W-1:0]   bg_q,          bg_d;
  logic               flash_en_q,    flash_en_d;
  logic [CNT_W-1:0]   frame_cnt_q,   frame_cnt_d;
  logic               flash_phase_q, flash_phase_d;

  // Stage-2 output registers
  logic [RGB_W-1:0]   rgb_q,         rgb_d;
  logic               rgb_valid_q;
  logic               frame_start_q;

  rect_frame_hit #(
    .COORD_W (COORD_W),
    .X0      (BX0),
    .Y0      (BY0),
    .X1      (BX1),
    .Y1      (BY1),
    .THICK   (THICK)
  ) u_border_hit (
    .x_i   (bus.pix_x),
    .y_i   (bus.pix_y),
    .hit_o (in_border)
  );

  assign sof = is_frame_start(bus.pix_x == '0, bus.pix_y == '0, bus.video_on);

  // Stage 1: capture the pixel's layer inputs and border hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      graph_on_q  <= 1'b0;
      graph_rgb_q <= '0;
      video_on_q  <= 1'b0;
      in_border_q <= 1'b0;
      sof_q       <= 1'b0;
    end else begin
      graph_on_q  <= bus.graph_on;
      graph_rgb_q <= bus.graph_rgb;
      video_on_q  <= bus.video_on;
      in_border_q <= in_border;
      sof_q       <= sof;
    end
  end

  // Frame-start latch and flash counter. The latch fires on the edge that
  // registers the (0,0) pixel, so that pixel's stage-2 decision already
  // sees the new colours and phase. The counter looks at the flash enable
  // that was in force for the frame just ending, hence disabling flash
  // only takes visible effect one frame after the request is latched.
  always_comb begin
    border_d      = border_q;
    bg_d          = bg_q;
    flash_en_d    = flash_en_q;
    frame_cnt_d   = frame_cnt_q;
    flash_phase_d = flash_phase_q;
    if (sof) begin
      border_d   = bus.border_rgb_in;
      bg_d       = bus.bg_rgb_in;
      flash_en_d = bus.flash_en;
      if (flash_en_q) begin
        if (frame_cnt_q == CNT_LAST) begin
          frame_cnt_d   = '0;
          flash_phase_d = !flash_phase_q;
        end else begin
          frame_cnt_d   = frame_cnt_q + 1'b1;
        end
      end else begin
        frame_cnt_d   = '0;
        flash_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      border_q      <= '1;
      bg_q          <= RGB_W'(1);
      flash_en_q    <= 1'b0;
      frame_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      border_q      <= border_d;
      bg_q          <= bg_d;
      flash_en_q    <= flash_en_d;
      frame_cnt_q   <= frame_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  // Stage 2 priority: blanking, then game layer, then (unflashed) border,
  // then background.
  always_comb begin
    rgb_d = bg_q;
    if (!video_on_q) begin
      rgb_d = '0;
    end else if (graph_on_q) begin
      rgb_d = graph_rgb_q;
    end else if (in_border_q && !flash_phase_q) begin
      rgb_d = border_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q         <= '0;
      rgb_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      rgb_valid_q   <= video_on_q;
      frame_start_q <= sof_q;
    end
  end

  assign bus.rgb         = rgb_q;
  assign bus.rgb_valid   = rgb_valid_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/playfield_compositor.md
Name: playfield_compositor

Overview:
Parametrised pixel compositor between the game-logic layer and the HDMI/VGA output stage. Merges the game layer, a configurable rectangular playfield border and a background colour into one registered RGB stream. Adds frame-synchronous configuration latching, a frame-counted border flash mode and a fixed-latency pipeline with blanking. Successor to the fixed 3-bit, hard-coded-border top-level colour mux.

Parameters:
COORD_W, 10, width of pixel coordinates
RGB_W, 3, colour word width
BX0, 150, border outer left x (inclusive)
BY0, 110, border outer top y (inclusive)
BX1, 489, border outer right x (inclusive)
BY1, 370, border outer bottom y (inclusive)
THICK, 10, border thickness in pixels; must be >=1 and <= (BX1-BX0+1)/2
FLASH_FRAMES, 30, frames per flash half-period; must be >=1

Ports:
clk  in  1  pixel-rate clock
reset  in  1  synchronous, active-high reset
pix_x  in  COORD_W  current pixel x
pix_y  in  COORD_W  current pixel y
video_on  in  1  active-video qualifier for this pixel
graph_on  in  1  game layer wants this pixel
graph_rgb  in  RGB_W  game layer colour
border_rgb_in  in  RGB_W  requested border colour (latched at frame start)
bg_rgb_in  in  RGB_W  requested background colour (latched at frame start)
flash_en  in  1  request border flash (latched at frame start)
rgb  out  RGB_W  composited colour
rgb_valid  out  1  video_on delayed to align with rgb
frame_start  out  1  one-cycle pulse aligned with rgb for pixel (0,0)

Behaviour:
- One clock, synchronous active-high reset. Reset values: rgb=0, rgb_valid=0, frame_start=0, border_q=all-ones, bg_q=1, flash_en_q=0, frame_cnt=0, flash_phase=0, pipeline regs cleared.
- Latency: fixed 2 cycles from inputs to rgb/rgb_valid/frame_start.
- Stage 1 (registered): in_border = inside outer rectangle [BX0..BX1]x[BY0..BY1] AND NOT inside inner rectangle [BX0+THICK..BX1-THICK]x[BY0+THICK..BY1-THICK]; compares unsigned at COORD_W. Register graph_on, graph_rgb, video_on, in_border, sof = (pix_x==0 && pix_y==0 && video_on).
- Frame-start latch: on stage-1 sof, border_q<=border_rgb_in, bg_q<=bg_rgb_in, flash_en_q<=flash_en. Mid-frame changes of these inputs are ignored until next frame start.
- Flash counter: on each sof, if flash_en_q (value before this update) is 1: frame_cnt increments; when frame_cnt==FLASH_FRAMES-1 it wraps to 0 and flash_phase toggles. If flash_en_q is 0: frame_cnt<=0, flash_phase<=0. Border visible when flash_phase==0.
- Stage 2 priority (registered to rgb): !video_on_s1 -> 0; else graph_on_s1 -> graph_rgb_s1; else in_border_s1 && !flash_phase -> border_q; else bg_q. Game layer always overrides border.
- rgb_valid/frame_start are the stage-1 video_on/sof registered once more.
- Colour used in stage 2 is the latched value in effect at that cycle; the sof pixel itself uses the newly latched colours (latch and stage 2 both act on the sof cycle edge: stage 2 uses the registered new value one cycle later, consistent because sof pixel's stage 2 occurs after the latch edge).
- Reset asserted mid-frame: all outputs 0 on next edge; flash restarts phase 0; colours revert to reset defaults until next sof.
- Coordinates outside the active area with video_on=0 produce rgb=0 regardless of layers.

Decomposition:
- Shared package (video_pkg): COORD_W/RGB_W defaults, colour constants (BLACK, BLUE=1, WHITE=all-ones), default playfield geometry.
- One natural sub-module: rect_frame_hit (combinational outer-minus-inner rectangle test, parameterised by bounds and THICK), reused later for score boxes.

Test Plan:
- Reset then pixel (155,200), video_on=1, graph_on=0, defaults -> 2 cycles later rgb=3'b111, rgb_valid=1.
- Pixel (300,200) inside field, graph_on=0 -> rgb=bg_q=3'b001; same pixel graph_on=1, graph_rgb=3'b010 -> rgb=3'b010; border pixel (485,365) with graph_on=1, graph_rgb=3'b100 -> 3'b100.
- Boundaries: (149,200)->bg, (150,200)->border, (159,200)->border, (160,200)->bg, (489,370)->border, (490,370)->bg.
- Change border_rgb_in to 3'b011 mid-frame -> border stays 3'b111 until next (0,0); from first frame after, border pixels =3'b011; frame_start pulses exactly once per frame, 2 cycles after (0,0).
- flash_en=1, FLASH_FRAMES=2 -> border shown in frames with phase 0, replaced by bg for 2 frames, then restored, period 4 frames; deassert flash_en -> border solid from next-but-one frame.
- Assert reset during active line -> next cycle rgb=0, rgb_valid=0, frame_start=0; after release colours are defaults, flash_phase=0.
